pokey_audio_mixer: RTL and testbench

POKEY_AUDIO_MIXER -- requirements
Module: pokey_audio_mixer

---
 rtl/pokey_audio_mixer.sv | 93 +++++++++
 tb/tb_pokey_audio_mixer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pokey_audio_mixer.sv
// Four-channel POKEY volume mixer feeding a 1-bit PWM or first-order sigma-delta
// modulator; the mixed sample is re-latched once per 2^PERIOD_BITS-cycle period.
module pokey_audio_mixer #(
  parameter int PERIOD_BITS = 6
) (
  input  logic       clk179,
  input  logic       init_L,
  input  logic       audio1,
  input  logic       audio2,
  input  logic       audio3,
  input  logic       audio4,
  input  logic [3:0] vol1,
  input  logic [3:0] vol2,
  input  logic [3:0] vol3,
  input  logic [3:0] vol4,
  input  logic [3:0] chanEn,
  input  logic       mode,
  output logic       pwmOut,
  output logic [5:0] sample,
  output logic       sampleStrobe
);

  localparam int PW  = PERIOD_BITS;
  localparam int PW1 = PERIOD_BITS + 1;

  logic [3:0]    audio_r;
  logic [3:0]    en_r;
  logic [3:0]    vol_r [4];
  logic [5:0]    sum;
  logic [PW-1:0] p_cnt;
  logic [PW-1:0] p_cnt_next;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_base;
  logic [PW:0]   sd_sum;
  logic [5:0]    sample_next;
  logic          mode_l;
  logic          mode_next;
  logic          boundary;

  // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int n = 0; n < 4; n++) begin
      if (audio_r[n] && en_r[n]) sum = sum + 6'(vol_r[n]);
    end
  end

  assign boundary = &p_cnt;

  // Outputs are computed from next-state values so pwmOut lines up with the pCnt it is shown in.
  always_comb begin
    p_cnt_next  = p_cnt + PW'(1);
    sample_next = boundary ? sum : sample;
    mode_next   = boundary ? mode : mode_l;
    // Entering sigma-delta restarts the accumulator from zero at the boundary.
    acc_base    = (boundary && mode && !mode_l) ? '0 : acc;
    sd_sum      = {1'b0, acc_base} + PW1'(sample_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk179) begin
    if (!init_L) begin
      audio_r      <= '0;
      en_r         <= '0;
      for (int n = 0; n < 4; n++) vol_r[n] <= '0;
      p_cnt        <= '0;
      acc          <= '0;
      sample       <= '0;
      mode_l       <= 1'b0;
      pwmOut       <= 1'b0;
      sampleStrobe <= 1'b0;
    end else begin
      audio_r      <= {audio4, audio3, audio2, audio1};
      en_r         <= chanEn;
      vol_r[0]     <= vol1;
      vol_r[1]     <= vol2;
      vol_r[2]     <= vol3;
      vol_r[3]     <= vol4;
      p_cnt        <= p_cnt_next;
      sample       <= sample_next;
      mode_l       <= mode_next;
      sampleStrobe <= boundary;
      if (mode_next) begin
        acc    <= sd_sum[PW-1:0];
        pwmOut <= sd_sum[PW];
      end else begin
        acc    <= '0;
        pwmOut <= (p_cnt_next < PW'(sample_next));
      end
    end
  end

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Scoreboard bench for pokey_audio_mixer: the driver queues per-period expectations,
// the monitor checks sample, high count and waveform shape at every strobe.
module tb_pokey_audio_mixer;

  logic       clk179 = 1'b0;
  logic       init_L = 1'b0;
  logic       audio1, audio2, audio3, audio4;
  logic [3:0] vol1, vol2, vol3, vol4;
  logic [3:0] chanEn;
  logic       mode;
  logic       pwmOut;
  logic [5:0] sample;
  logic       sampleStrobe;

  // pat: 0 = PWM shape (high while index < sample), 1 = one high every 4th cycle, 2 = count only
  typedef struct {
    logic [5:0] s;
    int         highs;
    int         pat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk179 = ~clk179;

  pokey_audio_mixer #(.PERIOD_BITS(6)) dut (
    .clk179       (clk179),
    .init_L       (init_L),
    .audio1       (audio1),
    .audio2       (audio2),
    .audio3       (audio3),
    .audio4       (audio4),
    .vol1         (vol1),
    .vol2         (vol2),
    .vol3         (vol3),
    .vol4         (vol4),
    .chanEn       (chanEn),
    .mode         (mode),
    .pwmOut       (pwmOut),
    .sample       (sample),
    .sampleStrobe (sampleStrobe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] v1, input logic [3:0] v2,
                       input logic [3:0] v3, input logic [3:0] v4, input logic [3:0] en,
                       input logic md);
    {audio4, audio3, audio2, audio1} = a;
    vol1 = v1; vol2 = v2; vol3 = v3; vol4 = v4;
    chanEn = en;
    mode = md;
  endtask

  task automatic push(input int s, input int highs, input int pat);
    exp_t e;
    e.s = 6'(s);
    e.highs = highs;
    e.pat = pat;
    q.push_back(e);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk179);
      n++;
    end while (!sampleStrobe && n < 200);
    if (!sampleStrobe) check("strobe_timeout", 32'(n), 32'd64);
  endtask

  // Hold reset for three edges, release, then time the first boundary.
  task automatic do_reset();
    logic ok;
    int   n;
    init_L = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk179);
      if (pwmOut !== 1'b0 || sample !== 6'd0 || sampleStrobe !== 1'b0) ok = 1'b0;
    end
    check("reset_outputs_zero", 32'(ok), 32'd1);
    init_L = 1'b1;
    n = 0;
    ok = 1'b1;
    do begin
      @(negedge clk179);
      n++;
      if (!sampleStrobe && (pwmOut !== 1'b0 || sample !== 6'd0)) ok = 1'b0;
    end while (!sampleStrobe && n < 200);
    check("first_boundary_edges", 32'(n), 32'd64);
    check("zero_until_boundary", 32'(ok), 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    int   highs;
    logic shape_ok;
    logic gap_ok;
    forever begin
      do @(negedge clk179); while (sampleStrobe !== 1'b1);
      if (q.size() == 0) continue;
      e = q.pop_front();
      check("sample_at_strobe", 32'(sample), 32'(e.s));
      highs = 0;
      shape_ok = 1'b1;
      gap_ok = 1'b1;
      for (int i = 0; i < 64; i++) begin
        if (i > 0) @(negedge clk179);
        if (pwmOut === 1'b1) highs++;
        if (sample !== e.s) shape_ok = 1'b0;
        if (i > 0 && sampleStrobe !== 1'b0) gap_ok = 1'b0;
        case (e.pat)
          0:       if (pwmOut !== (i < int'(e.s))) shape_ok = 1'b0;
          1:       if (pwmOut !== ((i % 4) == 3)) shape_ok = 1'b0;
          default: ;
        endcase
      end
      check("period_high_count", 32'(highs), 32'(e.highs));
      check("period_shape", 32'(shape_ok), 32'd1);
      check("strobe_single", 32'(gap_ok), 32'd1);
    end
  end

  initial begin : driver
    int n;
    drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    push(60, 60, 0);
    do_reset();                                        // period 1 starts
    push(60, 60, 0);
    wait_strobe(n);                                    // period 2
    check("strobe_interval", 32'(n), 32'd64);
    drive(4'b0101, 4'd5, 4'hF, 4'd9, 4'hF, 4'b1011, 1'b0);
    push(5, 5, 0);
    wait_strobe(n);                                    // period 3
    chanEn = 4'hF;
    push(14, 14, 0);
    wait_strobe(n);                                    // period 4
    drive(4'b0001, 4'd7, 4'd0, 4'd0, 4'd0, 4'hF, 1'b0);
    push(7, 7, 0);
    wait_strobe(n);                                    // period 5
    repeat (30) @(negedge clk179);
    vol1 = 4'd3;
    push(3, 3, 0);
    wait_strobe(n);                                    // period 6
    drive(4'b0000, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    push(0, 0, 0);
    wait_strobe(n);                                    // period 7
    push(0, 0, 0);
    wait_strobe(n);                                    // period 8
    drive(4'b0011, 4'hF, 4'd1, 4'd0, 4'd0, 4'hF, 1'b1);
    push(16, 16, 1);
    wait_strobe(n);                                    // period 9
    push(16, 16, 1);
    wait_strobe(n);                                    // period 10
    vol2 = 4'd5;
    push(20, 20, 2);
    wait_strobe(n);                                    // period 11
    repeat (63) @(negedge clk179);
    vol2 = 4'd1;                                       // registered on the boundary edge itself
    push(20, 20, 2);
    wait_strobe(n);                                    // period 12
    check("boundary_after_last_cycle", 32'(n), 32'd1);
    push(16, 16, 1);
    wait_strobe(n);                                    // period 13
    mode = 1'b0;
    push(16, 16, 0);
    wait_strobe(n);                                    // period 14
    mode = 1'b1;
    push(16, 16, 1);
    wait_strobe(n);                                    // period 15
    wait_strobe(n);                                    // period 16, not scoreboarded
    repeat (30) @(negedge clk179);
    do_reset();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
